// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and command constants for the SPI byte engine
//
// Purpose : command words, data_select codes, engine state encoding and the
//           selector-to-command lookup used when a frame is loaded.
// Ports   : none (package).
package spi_pkg;

  localparam logic [15:0] CMD_DUMMY    = 16'h0000;
  localparam logic [15:0] CMD_MEASURE  = 16'h2D08;
  localparam logic [15:0] CMD_READ     = 16'hF200;
  localparam logic [15:0] CMD_SOFT_RST = 16'h1F52;

  typedef enum logic [1:0] {
    SEL_DUMMY    = 2'b00,
    SEL_MEASURE  = 2'b01,
    SEL_READ     = 2'b10,
    SEL_SOFT_RST = 2'b11
  } sel_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } eng_state_t;

  function automatic logic [15:0] cmd_lookup(input sel_t sel);
    case (sel)
      SEL_MEASURE:  cmd_lookup = CMD_MEASURE;
      SEL_READ:     cmd_lookup = CMD_READ;
      SEL_SOFT_RST: cmd_lookup = CMD_SOFT_RST;
      default:      cmd_lookup = CMD_DUMMY;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_engine_if.sv
// rtl/spi_byte_engine_if.sv - request/pin bundle between command FSM, engine and SPI slave
//
// Purpose : groups the frame request inputs, the SPI pins and the frame
//           completion outputs of spi_byte_engine.
// Signals : data_select[1:0], transfer, receive, cs, spi_miso  -> engine
//           spi_sclk, spi_mosi, spi_cs_n, done,
//           rx_data[FRAME_BITS-1:0], rx_valid                 <- engine
// Modports: slave  = engine side, master = requester/bench side.
interface spi_byte_engine_if #(
  parameter int FRAME_BITS = 16
);

  logic [1:0]            data_select;
  logic                  transfer;
  logic                  receive;
  logic                  cs;
  logic                  spi_miso;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_cs_n;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;

  modport slave (
    input  data_select, transfer, receive, cs, spi_miso,
    output spi_sclk, spi_mosi, spi_cs_n, done, rx_data, rx_valid
  );

  modport master (
    output data_select, transfer, receive, cs, spi_miso,
    input  spi_sclk, spi_mosi, spi_cs_n, done, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period timer producing fall/rise strobes
//
// Purpose : counts CLK_DIV system clocks per SCLK half-period while enabled
//           and emits one-cycle strobes at the start of each half.
// Ports   : clk, reset (async, active low)
//           i_en         run the timer; low clears it to the bit-start phase
//           o_fall_tick  first cycle of a bit (SCLK falls)
//           o_rise_tick  first cycle of the second half (SCLK rises)
//           o_bit_end    last cycle of a bit
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_fall_tick,
  output logic o_rise_tick,
  output logic o_bit_end
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_phase;   // 0 = SCLK-low half, 1 = SCLK-high half
  logic          w_half_end;

  assign w_half_end = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_half_end) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_fall_tick = i_en && (r_cnt == '0) && !r_phase;
  assign o_rise_tick = i_en && (r_cnt == '0) &&  r_phase;
  assign o_bit_end   = i_en && w_half_end && r_phase;

endmodule

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - mode-3 fixed-width SPI frame engine
//
// Purpose : turns a command-FSM frame request into one SPI mode 3 frame
//           (CPOL=1, CPHA=1, MSB first) and reports completion.
// Ports   : clk, reset (async, active low)
//           bus (spi_byte_engine_if.slave): request inputs, SPI pins,
//           done / rx_data / rx_valid.
// Config  : SPI_LOOPBACK_EN - rx shifter samples the internal MOSI bit
//           instead of spi_miso.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  spi_byte_engine_if.slave    bus
);

  localparam int WW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);

  eng_state_t            r_state;
  eng_state_t            w_next;

  logic [WW-1:0]         r_wait;
  logic [BW-1:0]         r_bit;
  logic [FRAME_BITS-1:0] r_tx;
  logic [FRAME_BITS-1:0] r_rx;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic                  r_rx_frame;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs_n;

  logic                  w_fall;
  logic                  w_rise;
  logic                  w_bit_end;
  logic                  w_wait_end;
  logic                  w_last_bit;
  logic                  w_active;
  logic                  w_done;
  logic                  w_rx_valid;
  logic                  w_rx_bit;
  logic [31:0]           w_cmd_ext;
  logic [FRAME_BITS-1:0] w_load;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .reset       (reset),
    .i_en        (r_state == SHIFT),
    .o_fall_tick (w_fall),
    .o_rise_tick (w_rise),
    .o_bit_end   (w_bit_end)
  );

  // The 16-bit command sits at the MSB end; narrower frames drop LSBs,
  // wider frames pad zeros below it.
  assign w_cmd_ext = {cmd_lookup(sel_t'(bus.data_select)), 16'h0000};
  assign w_load    = FRAME_BITS'(w_cmd_ext >> (32 - FRAME_BITS));

`ifdef SPI_LOOPBACK_EN
  assign w_rx_bit = r_mosi;
`else
  assign w_rx_bit = bus.spi_miso;
`endif

  assign w_wait_end = (r_wait == WW'(CLK_DIV - 1));
  assign w_last_bit = (r_bit == BW'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_active   = 1'b0;
    w_done     = 1'b0;
    w_rx_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.transfer) w_next = LEAD;
      end
      LEAD: begin
        w_active = 1'b1;
        if (w_wait_end) w_next = SHIFT;
      end
      SHIFT: begin
        w_active = 1'b1;
        if (w_bit_end && w_last_bit) w_next = TRAIL;
      end
      TRAIL: begin
        w_active = 1'b1;
        if (w_wait_end) w_next = DONE;
      end
      DONE: begin
        w_done     = 1'b1;
        w_rx_valid = r_rx_frame;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait     <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_frame <= 1'b0;
      r_sclk     <= 1'b1;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_cs_n <= bus.cs | ~w_active;

      // LEAD and TRAIL share one setup/hold timer
      if ((r_state == LEAD || r_state == TRAIL) && !w_wait_end) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end

      if (r_state == IDLE) begin
        r_sclk <= 1'b1;
        r_mosi <= 1'b0;
        if (bus.transfer) begin
          r_tx       <= w_load;
          r_rx_frame <= bus.receive;
        end
      end

      if (w_fall) begin
        r_sclk <= 1'b0;
        r_mosi <= r_tx[FRAME_BITS-1];
        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
      end

      if (w_rise) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[FRAME_BITS-2:0], w_rx_bit};
      end

      if (w_bit_end) begin
        r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
      end

      if (r_state == TRAIL && w_wait_end && r_rx_frame) begin
        r_rx_data <= r_rx;
      end
    end
  end

  assign bus.spi_sclk = r_sclk;
  assign bus.spi_mosi = r_mosi;
  assign bus.spi_cs_n = r_cs_n;
  assign bus.done     = w_done;
  assign bus.rx_valid = w_rx_valid;
  assign bus.rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb/tb_spi_byte_engine.sv - directed self-checking bench for spi_byte_engine
module tb_spi_byte_engine;

  localparam int CLK_DIV = 4;
  localparam int FB      = 16;

  logic clk = 1'b0;
  logic reset;

  spi_byte_engine_if #(.FRAME_BITS(FB)) bus ();

  spi_byte_engine #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // pin monitor / slave model, sampled on the falling system clock edge
  int          n_fall = 0, n_rise = 0, n_done = 0, n_rxv = 0, n_csl = 0;
  int          fall_base = 0;
  int          mon_k;
  logic [31:0] mosi_sr = '0;
  logic [31:0] slave_word = '0;
  logic        prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (!reset) begin
      bus.spi_miso = 1'b0;
    end
    if (prev_sclk && !bus.spi_sclk) begin
      mon_k = n_fall - fall_base;
      bus.spi_miso = (mon_k >= 0 && mon_k < 32) ? slave_word[31-mon_k] : 1'b0;
      mosi_sr = {mosi_sr[30:0], bus.spi_mosi};
      n_fall++;
    end
    if (!prev_sclk && bus.spi_sclk) n_rise++;
    if (bus.done) n_done++;
    if (bus.rx_valid) n_rxv++;
    if (!bus.spi_cs_n) n_csl++;
    prev_sclk = bus.spi_sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget && at_cyc < 0; i++) begin
      @(negedge clk);
      if (bus.done) at_cyc = cyc;
    end
    check({tag, "_done_seen"}, 32'(at_cyc >= 0), 32'd1);
  endtask

  task automatic wait_falls(input string tag, input int base, input int n, input int budget);
    int i;
    for (i = 0; i < budget && (n_fall - base) < n; i++) @(negedge clk);
    check({tag, "_falls_seen"}, 32'((n_fall - base) >= n), 32'd1);
  endtask

  int t0, td1, td2, fb, rb, d0, v0, c0;
  logic [15:0] exp_a, exp_b, exp_lb;

  initial begin
    reset = 1'b0;
    bus.data_select = 2'b00;
    bus.transfer    = 1'b0;
    bus.receive     = 1'b0;
    bus.cs          = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_sclk",     32'(bus.spi_sclk), 32'd1);
    check("rst_mosi",     32'(bus.spi_mosi), 32'd0);
    check("rst_cs_n",     32'(bus.spi_cs_n), 32'd1);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data",  32'(bus.rx_data),  32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: async reset in bit 5 of a MEASURE frame (bit 5 of 2D08 is 1)
    bus.cs = 1'b0; bus.data_select = 2'b01; bus.transfer = 1'b1;
    fb = n_fall; d0 = n_done;
    @(negedge clk);
    bus.transfer = 1'b0;
    wait_falls("t1", fb, 6, 200);
    @(negedge clk);
    check("t1_mid_mosi", 32'(bus.spi_mosi), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t1_sclk", 32'(bus.spi_sclk), 32'd1);
    check("t1_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("t1_mosi", 32'(bus.spi_mosi), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check("t1_no_done", 32'(n_done - d0), 32'd0);

    // 2: single-cycle MEASURE request, latency and MOSI content
    bus.cs = 1'b0; bus.data_select = 2'b01; bus.receive = 1'b0; bus.transfer = 1'b1;
    t0 = cyc; fb = n_fall; rb = n_rise; d0 = n_done; v0 = n_rxv;
    @(negedge clk);
    bus.transfer = 1'b0;
    wait_done("t2", 200, td1);
    check("t2_latency", 32'(td1 - t0), 32'd137);
    repeat (5) @(negedge clk);
    check("t2_mosi_word", {16'h0, mosi_sr[15:0]}, 32'h2D08);
    check("t2_falls",     32'(n_fall - fb), 32'd16);
    check("t2_done_cnt",  32'(n_done - d0), 32'd1);
    check("t2_no_rxv",    32'(n_rxv - v0),  32'd0);

    // 3: back-to-back receive frames READ then DUMMY, slave sends 1234 / A5C3
`ifdef SPI_LOOPBACK_EN
    exp_a = 16'hF200; exp_b = 16'h0000;
`else
    exp_a = 16'h1234; exp_b = 16'hA5C3;
`endif
    fall_base = n_fall; slave_word = 32'h1234_A5C3;
    bus.data_select = 2'b10; bus.receive = 1'b1; bus.cs = 1'b0; bus.transfer = 1'b1;
    d0 = n_done; v0 = n_rxv;
    repeat (20) @(negedge clk);
    bus.data_select = 2'b00;
    check("t3_cs_n_f1", 32'(bus.spi_cs_n), 32'd0);
    wait_done("t3a", 200, td1);
    check("t3_rxv_f1",  32'(bus.rx_valid), 32'd1);
    check("t3_rx_f1",   32'(bus.rx_data),  32'(exp_a));
    check("t3_mosi_f1", {16'h0, mosi_sr[15:0]}, 32'hF200);
    repeat (30) @(negedge clk);
    check("t3_rx_hold", 32'(bus.rx_data),  32'(exp_a));
    check("t3_cs_n_f2", 32'(bus.spi_cs_n), 32'd0);
    wait_done("t3b", 200, td2);
    bus.transfer = 1'b0;
    check("t3_gap",     32'(td2 - td1),    32'd138);
    check("t3_rxv_f2",  32'(bus.rx_valid), 32'd1);
    check("t3_rx_f2",   32'(bus.rx_data),  32'(exp_b));
    repeat (10) @(negedge clk);
    check("t3_mosi_f2", {16'h0, mosi_sr[15:0]}, 32'h0000);
    check("t3_done_cnt", 32'(n_done - d0), 32'd2);
    check("t3_rxv_cnt",  32'(n_rxv - v0),  32'd2);

    // 4: SOFT_RST with upstream cs high - clock runs, pin stays deasserted
    bus.cs = 1'b1; bus.data_select = 2'b11; bus.receive = 1'b0; bus.transfer = 1'b1;
    fb = n_fall; rb = n_rise; d0 = n_done; c0 = n_csl;
    @(negedge clk);
    bus.transfer = 1'b0;
    wait_done("t4", 200, td1);
    repeat (5) @(negedge clk);
    check("t4_edges",     32'((n_fall - fb) + (n_rise - rb)), 32'd32);
    check("t4_cs_n_high", 32'(n_csl - c0), 32'd0);
    check("t4_done_cnt",  32'(n_done - d0), 32'd1);
    check("t4_mosi_word", {16'h0, mosi_sr[15:0]}, 32'h1F52);

    // 5: select and transfer change at bit 3 are ignored
    bus.cs = 1'b0; bus.data_select = 2'b01; bus.transfer = 1'b1;
    fb = n_fall; d0 = n_done;
    wait_falls("t5", fb, 4, 200);
    bus.data_select = 2'b11; bus.transfer = 1'b0;
    wait_done("t5", 200, td1);
    repeat (150) @(negedge clk);
    check("t5_mosi_word", {16'h0, mosi_sr[15:0]}, 32'h2D08);
    check("t5_done_cnt",  32'(n_done - d0), 32'd1);
    check("t5_falls",     32'(n_fall - fb), 32'd16);
    check("t5_idle_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("t5_idle_mosi", 32'(bus.spi_mosi), 32'd0);

    // 6: READ receive frame with MISO held low
`ifdef SPI_LOOPBACK_EN
    exp_lb = 16'hF200;
`else
    exp_lb = 16'h0000;
`endif
    fall_base = n_fall; slave_word = 32'h0;
    bus.data_select = 2'b10; bus.receive = 1'b1; bus.transfer = 1'b1;
    @(negedge clk);
    bus.transfer = 1'b0;
    wait_done("t6", 200, td1);
    check("t6_rxv", 32'(bus.rx_valid), 32'd1);
    check("t6_rx",  32'(bus.rx_data),  32'(exp_lb));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
